// File: rtl/ed_bin_integrator.sv
// Per-bin energy integrator over 2^k FFT frames with an adaptive detection threshold
// derived from the previous integration period's mean energy.
module ed_bin_integrator #(
   parameter int FFT_LEN      = 256,
   parameter int DW           = 32,
   parameter int MAX_LOG2_AVG = 4,
   parameter int SR_BASE      = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       set_stb,
   input  logic [7:0]                 set_addr,
   input  logic [31:0]                set_data,
   input  logic                       dv_in,
   input  logic [DW-1:0]              data_in,
   output logic                       dv_out,
   output logic [DW-1:0]              data_out,
   output logic [$clog2(FFT_LEN)-1:0] bin_out,
   output logic                       det_out,
   output logic                       sof_out
);

   localparam int BW     = $clog2(FFT_LEN);
   localparam int ACC_W  = DW + MAX_LOG2_AVG;
   localparam int FW     = (MAX_LOG2_AVG > 0) ? MAX_LOG2_AVG : 1;
   localparam int NW     = DW + BW;
   localparam int STAGES = 2;

   // settings registers
   logic        wr_k, wr_scale, wr_ctrl, clr;
   logic [3:0]  k_reg, k_act;
   logic [15:0] scale_reg, scale_act;
   logic        enable;

   assign wr_k     = set_stb && (set_addr == 8'(SR_BASE));
   assign wr_scale = set_stb && (set_addr == 8'(SR_BASE + 1));
   assign wr_ctrl  = set_stb && (set_addr == 8'(SR_BASE + 2));
   assign clr      = wr_ctrl && set_data[1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         k_reg     <= '0;
         scale_reg <= 16'h0100;
         enable    <= 1'b0;
      end else begin
         if (wr_k)
            k_reg <= (set_data[3:0] > 4'(MAX_LOG2_AVG)) ? 4'(MAX_LOG2_AVG) : set_data[3:0];
         if (wr_scale)
            scale_reg <= set_data[15:0];
         if (wr_ctrl)
            enable <= set_data[0];
      end
   end

   // bin / frame counters and shadow configuration
   logic [BW-1:0] bin_cnt;
   logic [FW-1:0] frame_cnt, frame_max;
   logic          accept, bin_last, frame_last, boundary;

   assign accept     = enable && dv_in && !clr;
   assign frame_max  = FW'((32'd1 << k_act) - 32'd1);
   assign bin_last   = (bin_cnt == BW'(FFT_LEN - 1));
   assign frame_last = (frame_cnt == frame_max);
   assign boundary   = (bin_cnt == '0) && (frame_cnt == '0) && !accept;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bin_cnt   <= '0;
         frame_cnt <= '0;
      end else if (clr || !enable) begin
         bin_cnt   <= '0;
         frame_cnt <= '0;
      end else if (accept) begin
         bin_cnt <= bin_cnt + 1'b1;
         if (bin_last)
            frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
      end
   end

   // config only changes between periods so one period never mixes two k values
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         k_act     <= '0;
         scale_act <= 16'h0100;
      end else if (clr || boundary) begin
         k_act     <= k_reg;
         scale_act <= scale_reg;
      end
   end

   // accumulator array; frame 0 overwrites, so no clearing pass is needed
   logic [ACC_W-1:0] acc [FFT_LEN];
   logic [ACC_W-1:0] acc_rd, sum, sum_sh;
   logic [DW-1:0]    avg;

   assign acc_rd = (frame_cnt == '0) ? '0 : acc[bin_cnt];
   assign sum    = acc_rd + ACC_W'(data_in);
   assign sum_sh = sum >> k_act;
   assign avg    = sum_sh[DW-1:0];

   always_ff @(posedge clock) begin
      if (accept)
         acc[bin_cnt] <= sum;
   end

   // threshold from previous period's mean, saturated to DW bits
   logic [NW-1:0]    noise_acc, noise_sum;
   logic [DW-1:0]    noise_prev, thr;
   logic             noise_valid;
   logic [DW+15:0]   prod;

   assign prod = {16'd0, noise_prev} * {{DW{1'b0}}, scale_act};
   assign thr  = (|prod[DW+15:DW+8]) ? '1 : prod[DW+7:8];

   // two-stage output pipeline
   logic [STAGES:1] vld_pipe;
   logic [DW-1:0]   s1_avg;
   logic [BW-1:0]   s1_bin;
   logic            s2_go;

   assign s2_go     = vld_pipe[1] && enable && !clr;
   assign noise_sum = noise_acc + NW'(s1_avg);
   assign dv_out    = vld_pipe[STAGES];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_pipe    <= '0;
         s1_avg      <= '0;
         s1_bin      <= '0;
         data_out    <= '0;
         bin_out     <= '0;
         det_out     <= 1'b0;
         sof_out     <= 1'b0;
         noise_acc   <= '0;
         noise_prev  <= '0;
         noise_valid <= 1'b0;
      end else begin
         vld_pipe[1] <= accept && frame_last;
         if (accept && frame_last) begin
            s1_avg <= avg;
            s1_bin <= bin_cnt;
         end
         vld_pipe[2] <= s2_go;
         // noise_prev updates on the same edge, so detection sees the old period
         det_out     <= s2_go && noise_valid && (s1_avg > thr);
         sof_out     <= s2_go && (s1_bin == '0);
         if (s2_go) begin
            data_out <= s1_avg;
            bin_out  <= s1_bin;
         end
         if (clr) begin
            noise_acc   <= '0;
            noise_prev  <= '0;
            noise_valid <= 1'b0;
         end else if (s2_go) begin
            if (s1_bin == BW'(FFT_LEN - 1)) begin
               noise_prev  <= noise_sum[NW-1:BW];
               noise_acc   <= '0;
               noise_valid <= 1'b1;
            end else begin
               noise_acc <= noise_sum;
            end
         end
      end
   end

endmodule
